// File: rtl/maxnet_iterator.sv
// Iterative Maxnet lateral-inhibition stage for a four-neuron winner-take-all network.
// Loads clamped activations, alternates CHECK/UPDATE until the detector reports one survivor.
module maxnet_iterator #(
  parameter logic signed [31:0] EPS      = 32'sd13107,
  parameter int                 FRAC     = 16,
  parameter int                 MAX_ITER = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] in1,
  input  logic signed [31:0] in2,
  input  logic signed [31:0] in3,
  input  logic signed [31:0] in4,
  input  logic               single_active,
  output logic signed [31:0] x1,
  output logic signed [31:0] x2,
  output logic signed [31:0] x3,
  output logic signed [31:0] x4,
  output logic               busy,
  output logic               done,
  output logic [3:0]         winner,
  output logic               timeout,
  output logic [7:0]         iter_count
);

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE} state_t;

  state_t             state;
  logic signed [31:0] xr    [4];
  logic signed [31:0] xnext [4];
  logic signed [33:0] s     [4];
  logic signed [65:0] p     [4];
  logic signed [65:0] diff  [4];
  logic [3:0]         onehot;
  logic signed [31:0] best;

  assign x1 = xr[0];
  assign x2 = xr[1];
  assign x3 = xr[2];
  assign x4 = xr[3];

  // Each neuron is inhibited by EPS times the sum of the other three, then ReLU'd.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s[i] = 34'sd0;
      for (int j = 0; j < 4; j++) begin
        if (j != i) s[i] = s[i] + 34'(xr[j]);
      end
      p[i]    = (66'(EPS) * 66'(s[i])) >>> FRAC;
      diff[i] = 66'(xr[i]) - p[i];
      if (diff[i] <= 0)
        xnext[i] = 32'sd0;
      else if (diff[i] > 66'sh7FFFFFFF)
        xnext[i] = 32'sh7FFFFFFF;
      else
        xnext[i] = diff[i][31:0];
    end
  end

  // Strict greater-than keeps the lowest index on ties; zero activations never win.
  always_comb begin
    onehot = 4'b0000;
    best   = 32'sd0;
    for (int i = 0; i < 4; i++) begin
      if (xr[i] > best) begin
        best      = xr[i];
        onehot    = 4'b0000;
        onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) xr[i] <= 32'sd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      winner     <= 4'b0000;
      timeout    <= 1'b0;
      iter_count <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr[0]      <= in1[31] ? 32'sd0 : in1;
            xr[1]      <= in2[31] ? 32'sd0 : in2;
            xr[2]      <= in3[31] ? 32'sd0 : in3;
            xr[3]      <= in4[31] ? 32'sd0 : in4;
            iter_count <= 8'd0;
            winner     <= 4'b0000;
            timeout    <= 1'b0;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (single_active || iter_count == 8'(MAX_ITER)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            winner  <= onehot;
            timeout <= !single_active;
            state   <= IDLE;
          end else begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 4; i++) xr[i] <= xnext[i];
          iter_count <= iter_count + 8'd1;
          state      <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_iterator.sv
// Randomized and directed bench for maxnet_iterator against a plain-arithmetic Maxnet model.
module tb_maxnet_iterator;

  localparam int  MI  = 4;
  localparam longint EPSL = 13107;
  localparam longint SATMAX = 64'h7FFFFFFF;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [31:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic               single_active;
  logic signed [31:0] x1, x2, x3, x4;
  logic               busy, done, timeout;
  logic [3:0]         winner;
  logic [7:0]         iter_count;

  int total = 0;
  int bad   = 0;

  longint traj [MI+1][4];
  int     mIter;
  bit     mTimeout;
  int     mWinner;
  longint firstX1;

  maxnet_iterator #(.EPS(32'sd13107), .FRAC(16), .MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .single_active(single_active),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .busy(busy), .done(done), .winner(winner),
    .timeout(timeout), .iter_count(iter_count)
  );

  // Stand-in for the downstream termination detector.
  assign single_active = (int'(x1 > 0) + int'(x2 > 0) + int'(x3 > 0) + int'(x4 > 0)) <= 1;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint dutX(input int i);
    case (i)
      0: return longint'(x1);
      1: return longint'(x2);
      2: return longint'(x3);
      default: return longint'(x4);
    endcase
  endfunction

  // Reference Maxnet: ReLU of x - EPS*(sum of others), run until <=1 positive or MI updates.
  task automatic modelRun(input longint a0, input longint a1, input longint a2, input longint a3);
    longint x [4];
    longint nx [4];
    longint sum, pen, best;
    int     pos;
    x[0] = a0 < 0 ? 0 : a0;
    x[1] = a1 < 0 ? 0 : a1;
    x[2] = a2 < 0 ? 0 : a2;
    x[3] = a3 < 0 ? 0 : a3;
    for (int i = 0; i < 4; i++) traj[0][i] = x[i];
    mIter = 0;
    forever begin
      pos = 0;
      for (int i = 0; i < 4; i++) if (x[i] > 0) pos++;
      if (pos <= 1) begin mTimeout = 0; break; end
      if (mIter == MI) begin mTimeout = 1; break; end
      for (int i = 0; i < 4; i++) begin
        sum   = x[0] + x[1] + x[2] + x[3] - x[i];
        pen   = (EPSL * sum) >>> 16;
        nx[i] = x[i] - pen;
        if (nx[i] < 0) nx[i] = 0;
        if (nx[i] > SATMAX) nx[i] = SATMAX;
      end
      x = nx;
      mIter++;
      for (int i = 0; i < 4; i++) traj[mIter][i] = x[i];
    end
    mWinner = 0;
    best    = 0;
    for (int i = 0; i < 4; i++) begin
      if (x[i] > best) begin best = x[i]; mWinner = 1 << i; end
    end
  endtask

  // One full run; glitchAt>0 pulses a second start with other inputs at that cycle.
  task automatic applyStimulus(input string tag, input int a0, input int a1, input int a2,
                               input int a3, input int glitchAt);
    int cycles;
    int k;
    int expLat;
    modelRun(a0, a1, a2, a3);
    expLat = 2 + 2 * mIter;
    in1 = a0; in2 = a1; in3 = a2; in4 = a3;
    start   = 1'b1;
    cycles  = 0;
    firstX1 = -1;
    do begin
      @(posedge clk); #1;
      cycles++;
      start = (glitchAt != 0 && cycles == glitchAt);
      if (start) begin
        in1 = int'($urandom); in2 = int'($urandom_range(100, 90000));
        in3 = int'($urandom_range(0, 70000)); in4 = int'($urandom_range(0, 500));
      end
      if (cycles == 3) firstX1 = longint'(x1);
      if (cycles < expLat) checkOutput({tag, " busy"}, busy, 1);
      if (cycles % 2 == 1) begin
        k = (cycles - 1) / 2;
        if (k <= mIter)
          for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s x%0d@upd%0d", tag, i + 1, k), dutX(i), traj[k][i]);
      end
    end while (!done && cycles < 2 + 2 * MI + 4);
    start = 1'b0;
    checkOutput({tag, " done seen"}, done, 1);
    checkOutput({tag, " latency"}, cycles, expLat);
    checkOutput({tag, " winner"}, winner, mWinner);
    checkOutput({tag, " timeout"}, timeout, mTimeout);
    checkOutput({tag, " iter_count"}, iter_count, mIter);
    checkOutput({tag, " busy at done"}, busy, 0);
    @(posedge clk); #1;
    checkOutput({tag, " done pulse"}, done, 0);
    checkOutput({tag, " winner held"}, winner, mWinner);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s x%0d held", tag, i + 1), dutX(i), traj[mIter][i]);
  endtask

  initial begin
    #2;
    checkOutput("reset x1", x1, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset winner", winner, 0);
    checkOutput("reset iter_count", iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("single", 0, 0, 65536, 0, 0);
    checkOutput("single winner literal", winner, 4'b0100);
    checkOutput("single iter literal", iter_count, 0);

    applyStimulus("oneupd", 65536, 32768, 16384, 8192, 0);
    checkOutput("oneupd first x1", firstX1, 54068);
    checkOutput("oneupd winner literal", winner, 4'b0001);
    checkOutput("oneupd timeout literal", timeout, 0);

    applyStimulus("clamp", -5, -1, 0, 0, 0);
    checkOutput("clamp winner literal", winner, 4'b0000);

    applyStimulus("tie", 65536, 65536, 0, 0, 0);
    checkOutput("tie timeout literal", timeout, 1);
    checkOutput("tie iter literal", iter_count, 4);
    checkOutput("tie winner literal", winner, 4'b0001);

    applyStimulus("startbusy", 40000, 90000, 70000, 1000, 3);

    // Asynchronous reset in the middle of a run, away from any clock edge.
    in1 = 65536; in2 = 65536; in3 = 0; in4 = 0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset x1", x1, 0);
    checkOutput("midreset x2", x2, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset winner", winner, 0);
    checkOutput("midreset timeout", timeout, 0);
    checkOutput("midreset iter_count", iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("afterreset", 30000, 65536, 20000, 0, 0);

    for (int r = 0; r < 24; r++) begin
      int v [4];
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: v[i] = -int'($urandom_range(1, 100000));
          1: v[i] = 0;
          2: v[i] = int'($urandom_range(1, 200000));
          default: v[i] = int'($urandom >> $urandom_range(1, 12));
        endcase
      end
      applyStimulus($sformatf("rand%0d", r), v[0], v[1], v[2], v[3], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
